// File: rtl/sha256_msg_padder_if.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder_if
//
// Purpose: bundles the two handshake streams of the SHA-256 message padder.
//   Input stream  : 32-bit big-endian message words, in_last / in_bytes mark
//                   the final word and how many of its bytes are valid.
//   Output stream : complete 512-bit padded blocks tagged first / last.
//
// Signals:
//   in_valid   word present              (source -> padder)
//   in_ready   padder accepts a word     (padder -> source)
//   in_data    message word, first byte in [31:24]
//   in_last    word ends the message
//   in_bytes   valid bytes in the last word (0..4, >4 means 4)
//   out_valid  out_block holds a padded block
//   out_ready  consumer takes the block
//   out_block  padded block, word 0 at [511:480]
//   out_first  block is the first of its message
//   out_last   block is the final block of its message
//
// Modports:
//   master  message source / block consumer side (the environment)
//   slave   padder side
// ---------------------------------------------------------------------------
interface sha256_msg_padder_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_block;
    logic         out_first;
    logic         out_last;

    modport master (
        output in_valid, in_data, in_last, in_bytes, out_ready,
        input  in_ready, out_valid, out_block, out_first, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, out_ready,
        output in_ready, out_valid, out_block, out_first, out_last
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder
//
// Purpose: collects a byte message delivered as 32-bit big-endian words and
// emits FIPS 180-4 padded 512-bit blocks (0x80 marker, zero fill, 64-bit
// big-endian bit length). Blocks are tagged first/last so the chaining
// controller knows when to load the IV and when the digest is final.
// out_block word 0 sits at [511:480], matching the compression core's
// value input.
//
// Parameters:
//   LEN_W  width of the byte-length counter (<= 64); the bit length placed in
//          the block is the counter times 8, zero-extended to 64 bits.
//
// Ports:
//   clk    clock, all logic on the rising edge
//   rst_n  synchronous active-low reset
//   bus    sha256_msg_padder_if.slave (input word stream, output block stream)
//
// The padder holds one block only: it either fills (in_ready = 1) or emits
// (out_valid = 1), never both.
// ---------------------------------------------------------------------------
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sha256_msg_padder_if.slave    bus
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,   // accepting message words
        EMIT  = 2'd1,   // presenting the block built from the buffer
        EXTRA = 2'd2    // presenting the trailing length-only block
    } state_t;

    state_t state, state_next;

    // Word buffer and counters
    logic [31:0]      word_q [16];
    logic [3:0]       wc;
    logic [LEN_W-1:0] len_q;
    logic             first_pending;

    // Extra-block bookkeeping, decided when the last word is accepted
    logic             extra_pend;   // a length-only block follows the current one
    logic             extra_lead;   // that block starts with the 0x80 marker

    // Registered outputs
    logic             out_valid_q;
    logic             out_first_q;
    logic             out_last_q;
    logic [511:0]     out_block_q;

    // Combinational helpers
    logic             accept;
    logic             emit_hs;
    logic             block_done;
    logic [2:0]       k;
    logic [31:0]      keep_mask;
    logic [31:0]      marker;
    logic [4:0]       p;
    logic [LEN_W-1:0] len_new;
    logic [63:0]      len_field_new;
    logic [63:0]      len_field_q;
    logic [511:0]     fill_block;
    logic [511:0]     extra_block;

    assign bus.in_ready  = rst_n && (state == FILL);
    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_block = out_block_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign emit_hs    = out_valid_q && bus.out_ready;
    assign block_done = accept && (bus.in_last || (wc == 4'd15));

    // -----------------------------------------------------------------------
    // Last-word decode: byte mask, position of the 0x80 marker and the new
    // length. For k = 4 the marker moves to byte 0 of the following word.
    // -----------------------------------------------------------------------
    // NOTE: every signal written in always_comb gets a value on every path
    // (defaults or full case coverage), otherwise a latch is inferred.
    always_comb begin
        k = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
        case (k)
            3'd0:    begin keep_mask = 32'h0000_0000; marker = 32'h8000_0000; end
            3'd1:    begin keep_mask = 32'hFF00_0000; marker = 32'h0080_0000; end
            3'd2:    begin keep_mask = 32'hFFFF_0000; marker = 32'h0000_8000; end
            3'd3:    begin keep_mask = 32'hFFFF_FF00; marker = 32'h0000_0080; end
            default: begin keep_mask = 32'hFFFF_FFFF; marker = 32'h8000_0000; end
        endcase
        p             = {1'b0, wc} + ((k == 3'd4) ? 5'd1 : 5'd0);
        len_new       = len_q + LEN_W'(k);
        len_field_new = 64'(len_new) << 3;
        len_field_q   = 64'(len_q) << 3;
    end

    // -----------------------------------------------------------------------
    // Block assembled from the buffer plus the word being accepted. Words
    // below wc come from the buffer, word wc is the incoming word (masked if
    // last), the marker lands at word p, and the length occupies words 14-15
    // only when the marker leaves room for it (p <= 13). With p = 16 no word
    // matches p, so the full data block goes out unmodified.
    // -----------------------------------------------------------------------
    always_comb begin
        fill_block = '0;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] w;
            w = 32'h0;
            if (5'(i) < {1'b0, wc}) begin
                w = word_q[i];
            end else if (5'(i) == {1'b0, wc}) begin
                w = bus.in_last ? (bus.in_data & keep_mask) : bus.in_data;
            end
            if (bus.in_last && (5'(i) == p)) begin
                w = w | marker;
            end
            if (bus.in_last && (p <= 5'd13)) begin
                if (i == 14) w = len_field_new[63:32];
                if (i == 15) w = len_field_new[31:0];
            end
            fill_block[511 - 32*i -: 32] = w;
        end
    end

    // Length-only trailer; the counter already holds the final length.
    assign extra_block = {(extra_lead ? 32'h8000_0000 : 32'h0), 416'h0, len_field_q};

    // -----------------------------------------------------------------------
    // FSM: state register and next-state logic
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (block_done) state_next = EMIT;
            EMIT:    if (emit_hs)    state_next = extra_pend ? EXTRA : FILL;
            EXTRA:   if (emit_hs)    state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // -----------------------------------------------------------------------
    // Word buffer
    // -----------------------------------------------------------------------
    // NOTE: the buffer is deliberately not reset: a word is only read back
    // after it has been written at a lower wc, so its reset value is never
    // observed.
    always_ff @(posedge clk) begin
        if ((state == FILL) && accept) begin
            word_q[wc] <= bus.in_data;
        end
    end

    // -----------------------------------------------------------------------
    // Counters, flags and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wc            <= 4'd0;
            len_q         <= '0;
            first_pending <= 1'b1;
            extra_pend    <= 1'b0;
            extra_lead    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_first_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_block_q   <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (bus.in_last) begin
                            len_q      <= len_new;
                            extra_pend <= (p >= 5'd14);
                            extra_lead <= (p == 5'd16);
                        end else begin
                            wc    <= wc + 4'd1;   // wraps 15 -> 0 on a full block
                            len_q <= len_q + LEN_W'(4);
                        end
                        if (block_done) begin
                            out_valid_q   <= 1'b1;
                            out_block_q   <= fill_block;
                            out_first_q   <= first_pending;
                            out_last_q    <= bus.in_last && (p <= 5'd13);
                            first_pending <= 1'b0;
                        end
                    end
                end

                EMIT: begin
                    if (emit_hs) begin
                        if (extra_pend) begin
                            // Trailer follows directly; out_valid stays high.
                            out_block_q <= extra_block;
                            out_first_q <= 1'b0;
                            out_last_q  <= 1'b1;
                            extra_pend  <= 1'b0;
                        end else begin
                            out_valid_q <= 1'b0;
                            wc          <= 4'd0;
                            if (out_last_q) begin
                                len_q         <= '0;
                                first_pending <= 1'b1;
                            end
                        end
                    end
                end

                EXTRA: begin
                    if (emit_hs) begin
                        out_valid_q   <= 1'b0;
                        wc            <= 4'd0;
                        len_q         <= '0;
                        first_pending <= 1'b1;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_padder
//
// Self-checking bench for sha256_msg_padder. Expected blocks come from a
// byte-level padding model (append 0x80, zero fill to 56 mod 64, append the
// 64-bit bit length, slice into 64-byte blocks). A table of message lengths
// with hand-derived block counts and final length words is applied in a
// loop, followed by hand-written sequences for reset, backpressure and reset
// mid-message, and a randomized run with random gaps and backpressure.
// ---------------------------------------------------------------------------
module tb_sha256_msg_padder;

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } blk_t;

    typedef struct {
        int          len;    // message length in bytes
        int          nblk;   // expected number of blocks
        logic [31:0] w15;    // expected word 15 of the final block
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sha256_msg_padder_if bus ();

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] msg_q [$];
    blk_t       exp_q [$];
    blk_t       rx_q  [$];
    int         ready_pct = 100;
    int         gap_pct   = 0;

    logic [511:0] abc_blk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference padding model
    task automatic build_model();
        logic [7:0] pad [$];
        logic [63:0] bitlen;
        int nb;
        blk_t b;
        exp_q.delete();
        pad = msg_q;
        bitlen = 64'(msg_q.size()) * 64'd8;
        pad.push_back(8'h80);
        while ((pad.size() % 64) != 56) pad.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pad.push_back(bitlen[8*i +: 8]);
        nb = pad.size() / 64;
        for (int bi = 0; bi < nb; bi++) begin
            for (int j = 0; j < 64; j++) b.blk[511 - 8*j -: 8] = pad[64*bi + j];
            b.first = (bi == 0);
            b.last  = (bi == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic make_msg(input int len, input int seed);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'(i * 7 + seed));
    endtask

    task automatic wait_accept();
        int cyc;
        logic took;
        cyc = 0;
        forever begin
            took = bus.in_ready;
            tick();
            if (took) break;
            cyc++;
            if (cyc > 2000) begin
                timeout_fail("in_accept");
                break;
            end
        end
    endtask

    task automatic drive_msg();
        int nw;
        nw = (msg_q.size() == 0) ? 1 : (msg_q.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            int k;
            while (int'($urandom_range(99)) < gap_pct) begin
                bus.in_valid = 1'b0;
                tick();
            end
            d = $urandom;   // unused bytes carry garbage that must be masked
            k = (w == nw - 1) ? msg_q.size() - 4*w : 4;
            for (int b = 0; b < k; b++) d[31 - 8*b -: 8] = msg_q[4*w + b];
            bus.in_data  = d;
            bus.in_last  = (w == nw - 1);
            bus.in_bytes = 3'(k);
            if (k == 4 && $urandom_range(1) == 1) bus.in_bytes = 3'(5 + $urandom_range(2));
            bus.in_valid = 1'b1;
            wait_accept();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic collect_msg();
        int cyc;
        bit done;
        logic rdy;
        blk_t r;
        cyc = 0;
        done = 0;
        while (!done) begin
            rdy = (int'($urandom_range(99)) < ready_pct);
            bus.out_ready = rdy;
            if (bus.out_valid) check("in_ready_low_while_valid", 512'(bus.in_ready), 512'(0));
            if (bus.out_valid && rdy) begin
                r.blk   = bus.out_block;
                r.first = bus.out_first;
                r.last  = bus.out_last;
                rx_q.push_back(r);
                if (r.last) done = 1;
            end
            tick();
            cyc++;
            if (cyc > 4000) begin
                timeout_fail("out_block");
                done = 1;
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic run_msg();
        int n;
        build_model();
        rx_q.delete();
        fork
            drive_msg();
            collect_msg();
        join
        check("num_blocks", 512'(rx_q.size()), 512'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("block_data",  rx_q[i].blk,          exp_q[i].blk);
            check("block_first", 512'(rx_q[i].first),  512'(exp_q[i].first));
            check("block_last",  512'(rx_q[i].last),   512'(exp_q[i].last));
        end
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{len: 3,   nblk: 1, w15: 32'h0000_0018};
        vecs[1] = '{len: 0,   nblk: 1, w15: 32'h0000_0000};
        vecs[2] = '{len: 55,  nblk: 1, w15: 32'h0000_01B8};
        vecs[3] = '{len: 56,  nblk: 2, w15: 32'h0000_01C0};
        vecs[4] = '{len: 64,  nblk: 2, w15: 32'h0000_0200};
        vecs[5] = '{len: 52,  nblk: 1, w15: 32'h0000_01A0};
        vecs[6] = '{len: 60,  nblk: 2, w15: 32'h0000_01E0};
        vecs[7] = '{len: 63,  nblk: 2, w15: 32'h0000_01F8};
        vecs[8] = '{len: 119, nblk: 2, w15: 32'h0000_03B8};
        vecs[9] = '{len: 128, nblk: 3, w15: 32'h0000_0400};

        abc_blk = {32'h6162_6380, 416'h0, 64'h18};

        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.in_bytes  = 3'd0;
        bus.out_ready = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_out_valid", 512'(bus.out_valid), 512'(0));
        check("rst_out_first", 512'(bus.out_first), 512'(0));
        check("rst_out_last",  512'(bus.out_last),  512'(0));
        check("rst_out_block", bus.out_block,       512'(0));
        check("rst_in_ready",  512'(bus.in_ready),  512'(0));
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 512'(bus.in_ready), 512'(1));

        // Table-driven lengths, always-ready consumer
        for (int i = 0; i < 10; i++) begin
            make_msg(vecs[i].len, i);
            run_msg();
            check("tbl_nblk", 512'(rx_q.size()), 512'(vecs[i].nblk));
            if (rx_q.size() > 0)
                check("tbl_w15", 512'(rx_q[rx_q.size()-1].blk[31:0]), 512'(vecs[i].w15));
        end

        // "abc" against the fixed expected block
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg();
        if (rx_q.size() > 0) begin
            check("abc_block", rx_q[0].blk, abc_blk);
            check("abc_first", 512'(rx_q[0].first), 512'(1));
            check("abc_last",  512'(rx_q[0].last),  512'(1));
        end

        // Empty message: block is just the marker
        msg_q.delete();
        run_msg();
        if (rx_q.size() > 0) check("empty_block", rx_q[0].blk, {32'h8000_0000, 480'h0});

        // Backpressure: block held 10 cycles, input stalled
        bus.in_data  = 32'h6162_63AA;
        bus.in_last  = 1'b1;
        bus.in_bytes = 3'd3;
        bus.in_valid = 1'b1;
        wait_accept();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("bp_valid_latency", 512'(bus.out_valid), 512'(1));
        for (int c = 0; c < 10; c++) begin
            check("bp_block_stable", bus.out_block,      abc_blk);
            check("bp_valid_held",   512'(bus.out_valid), 512'(1));
            check("bp_in_ready_low", 512'(bus.in_ready),  512'(0));
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_valid_drop",     512'(bus.out_valid), 512'(0));
        check("bp_in_ready_after", 512'(bus.in_ready),  512'(1));

        // Reset after 7 words: nothing emitted, next "abc" is clean
        for (int w = 0; w < 7; w++) begin
            bus.in_data  = $urandom;
            bus.in_last  = 1'b0;
            bus.in_bytes = 3'd4;
            bus.in_valid = 1'b1;
            wait_accept();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("midrst_out_valid", 512'(bus.out_valid), 512'(0));
        check("midrst_in_ready",  512'(bus.in_ready),  512'(0));
        rst_n = 1'b1;
        tick();
        check("midrst_no_block", 512'(bus.out_valid), 512'(0));
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg();
        if (rx_q.size() > 0) begin
            check("midrst_abc_block", rx_q[0].blk, abc_blk);
            check("midrst_abc_first", 512'(rx_q[0].first), 512'(1));
        end

        // Randomized messages with input gaps and output backpressure
        for (int m = 0; m < 14; m++) begin
            ready_pct = 30 + int'($urandom_range(70));
            gap_pct   = int'($urandom_range(30));
            make_msg(int'($urandom_range(140)), int'($urandom_range(255)));
            run_msg();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Upstream feeder for the SHA-256 compression core: accepts an arbitrary-length byte message as a stream of 32-bit big-endian words and emits FIPS 180-4 padded 512-bit blocks. Padding is one 0x80 byte, zero fill, then the 64-bit big-endian bit length. Each block is tagged first/last so the chaining controller knows when to load the IV or the previous result as `init` and when the digest is final. Output `out_block` word 0 is at bits [511:480], matching the core's `value` layout, so it connects directly to the core's `value` input.

## Interface
- LEN_W, 64: width of the internal bit-length counter (≤64); zero-extended into the 64-bit length field.

- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input word present
- in_ready  out  1  padder accepts a word this cycle
- in_data  in  32  message word; first byte in [31:24]
- in_last  in  1  this word ends the message
- in_bytes  in  3  valid bytes in the last word, 0..4; ignored unless in_last; values >4 treated as 4
- out_valid  out  1  `out_block` holds a complete padded block
- out_ready  in  1  consumer takes the block
- out_block  out  512  padded block, word 0 at [511:480]
- out_first  out  1  block is the first of its message
- out_last  out  1  block is the final block of its message

## Operation
- Buffer: 16×32 word registers, a 4-bit word counter `wc`, and an LEN_W-bit byte-length counter.
- Word accept: a word is accepted when in_valid & in_ready.
- Non-last word:
  - store at `wc` and increment `wc`.
  - add 4 to the length.
- `wc` wraps 15→0: block is full; the FSM goes to EMIT with out_first = first_pending and out_last = 0.
- Last word with k = in_bytes:
  - bytes ≥ k of the word are forced to 0.
  - length += k.
  - 0x80 is placed at byte k of word `wc`; if k = 4 it goes at byte 0 of word `wc`+1.
  - Let p be the word index holding 0x80, from 0 to 16.
- Final-block selection:
  - p ≤ 13: the remaining words are zero, words 14–15 = {64'(len×8)}, and a single final block is emitted.
  - p = 14 or 15: the current block is zero-filled after 0x80 and emitted with out_last = 0. It is followed by an extra block of all zeros with the length in words 14–15, which has out_last = 1.
  - p = 16 (k = 4, `wc` = 15): the current block is emitted with the data unmodified and out_last = 0. The extra block has word 0 = 0x80000000, zeros, then the length, and out_last = 1.
- Empty message: in_last with k = 0 at `wc` = 0 gives the block 0x80000000, 0…0, length 0.
- FSM states:
  - FILL: in_ready = 1. Moves to EMIT on a full block or on a last word.
  - EMIT: out_valid = 1. On handshake, goes to EXTRA if an extra block is pending; else goes to FILL, clearing `wc`, and also the length and setting first_pending if out_last.
  - EXTRA: out_valid = 1 with the extra block. On handshake, goes to FILL with full clear.
- out_first: asserted only on the first emitted block after reset or after an out_last handshake. The EXTRA block never carries out_first.
- Length arithmetic: the counter wraps modulo 2^LEN_W. Longer messages are unsupported, and no error is flagged.

## Timing
- Reset values (rst_n low at a clock edge):
  - state FILL, wc = 0, length = 0, first_pending = 1.
  - out_valid = 0, out_first = 0, out_last = 0, out_block = 0.
  - in_ready is forced to 0 while rst_n is low and reads 1 in the first cycle after release.
- Outputs are registered. out_valid rises in the cycle after the accept that completes a block or delivers in_last.
- in_ready = 0 whenever out_valid = 1. There is no overlap of fill and emit: the padder holds one block only.
- Out handshake rules:
  - out_block, out_first and out_last stay stable while out_valid & !out_ready.
  - out_valid never drops without a handshake.
- After the final handshake, in_ready = 1 in the next cycle.
- After an EMIT handshake with a pending extra block, the EXTRA block is valid in the next cycle.
- Throughput: 16 accept cycles plus at least 1 emit cycle per block, well inside the core's 65-cycle hash time.
- Reset mid-message or mid-emit: the partial message is discarded and the padder returns to the reset state at that edge. The next block carries out_first.

## Test plan
- "abc" (one word 0x61626300, in_last, k = 3) → 1 block: word 0 = 0x61626380, words 1–14 = 0, word 15 = 0x00000018; first = last = 1.
- Empty message (k = 0) → 1 block: word 0 = 0x80000000, all other words 0; first = last = 1.
- 55-byte message → 1 block, word 13 = 0xXXXXXX80, word 15 = 0x000001B8. 56-byte message → 2 blocks: the second is all-zero except word 15 = 0x000001C0; out_last only on the second.
- 64-byte message (16 words, last k = 4) → block 1 is the data (first = 1, last = 0); block 2 has word 0 = 0x80000000 and word 15 = 0x00000200 (first = 0, last = 1).
- Backpressure: hold out_ready = 0 for 10 cycles → out_block stable and in_ready = 0 throughout. Two messages sent back to back → the second message's first block has out_first = 1 and a length counted from 0.
- Assert rst_n = 0 after 7 words → no block emitted. A following "abc" yields exactly the block from the first scenario.
